// File: rtl/seven_segment_decoder_if.sv
// Segment-bus receive interface: seven raw segment lines toward the decoder,
// decoded hex value plus valid/error/update flags back from it.
interface seven_segment_decoder_if;
    logic       seg_a;
    logic       seg_b;
    logic       seg_c;
    logic       seg_d;
    logic       seg_e;
    logic       seg_f;
    logic       seg_g;
    logic [3:0] value;
    logic       valid;
    logic       error;
    logic       update;

    modport master (
        output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g,
        input  value, valid, error, update
    );

    modport slave (
        input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g,
        output value, valid, error, update
    );
endinterface

// File: rtl/seven_segment_decoder.sv
// Recovers a hex digit from seven (possibly asynchronous) segment lines once the
// synchronised pattern has been stable for STABLE_CYCLES clocks.
module seven_segment_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    seven_segment_decoder_if.slave  bus
);
    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [6:0]       POL_MASK = ACTIVE_LOW ? 7'h7f : 7'h00;

    // Returns {legal, value}; pattern order is {A,B,C,D,E,F,G}
    function automatic logic [4:0] decode_pattern(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'b1111110: res = {1'b1, 4'h0};
            7'b0110000: res = {1'b1, 4'h1};
            7'b1101101: res = {1'b1, 4'h2};
            7'b1111001: res = {1'b1, 4'h3};
            7'b0110011: res = {1'b1, 4'h4};
            7'b1011011: res = {1'b1, 4'h5};
            7'b1011111: res = {1'b1, 4'h6};
            7'b1110000: res = {1'b1, 4'h7};
            7'b1111111: res = {1'b1, 4'h8};
            7'b1110011: res = {1'b1, 4'h9};
            7'b1110111: res = {1'b1, 4'hA};
            7'b0011111: res = {1'b1, 4'hB};
            7'b1001110: res = {1'b1, 4'hC};
            7'b0111101: res = {1'b1, 4'hD};
            7'b1001111: res = {1'b1, 4'hE};
            7'b1000111: res = {1'b1, 4'hF};
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    logic [6:0]       seg_raw_s;
    logic [6:0]       sync1_r;
    logic [6:0]       sync2_r;
    logic [6:0]       pat_s;
    logic [6:0]       held_r;
    logic [6:0]       acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [4:0]       dec_s;
    logic             accept_s;
    logic [3:0]       value_r;
    logic             valid_r;
    logic             error_r;
    logic             update_r;

    assign seg_raw_s = {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d,
                        bus.seg_e, bus.seg_f, bus.seg_g};

    // Polarity correction, decode of the held pattern and the accept decision
    always_comb begin
        pat_s    = sync2_r ^ POL_MASK;
        dec_s    = decode_pattern(held_r);
        accept_s = (cnt_r == CNT_MAX) && (pat_s == held_r) && (held_r != acc_r);
    end

    // Two-flop synchroniser on all seven lines
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_r <= 7'b000_0000;
            sync2_r <= 7'b000_0000;
        end else begin
            sync1_r <= seg_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Stability tracker: any change restarts the run, a steady run saturates
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            held_r <= 7'b000_0000;
            cnt_r  <= '0;
        end else if (pat_s != held_r) begin
            held_r <= pat_s;
            cnt_r  <= CNT_ONE;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r  <= cnt_r + CNT_ONE;
        end else begin
            cnt_r  <= cnt_r;
        end
    end

    // Publish stage; an illegal pattern keeps the last good value on o_value
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_r    <= 7'b000_0000;
            value_r  <= 4'h0;
            valid_r  <= 1'b0;
            error_r  <= 1'b0;
            update_r <= 1'b0;
        end else begin
            update_r <= accept_s;
            if (accept_s) begin
                acc_r <= held_r;
                if (dec_s[4]) begin
                    value_r <= dec_s[3:0];
                    valid_r <= 1'b1;
                    error_r <= 1'b0;
                end else begin
                    value_r <= value_r;
                    valid_r <= 1'b0;
                    error_r <= 1'b1;
                end
            end else begin
                acc_r   <= acc_r;
                value_r <= value_r;
                valid_r <= valid_r;
                error_r <= error_r;
            end
        end
    end

    assign bus.value  = value_r;
    assign bus.valid  = valid_r;
    assign bus.error  = error_r;
    assign bus.update = update_r;
endmodule
